// File: rtl/hash_word_sequencer_if.sv
// Hash hand-off bus between the mining core (master) and the word sequencer (slave).
interface hash_word_sequencer_if;
  logic [255:0] hash_in;
  logic         hash_valid;
  logic         hash_ready;

  modport master (
    output hash_in,
    output hash_valid,
    input  hash_ready
  );

  modport slave (
    input  hash_in,
    input  hash_valid,
    output hash_ready
  );
endinterface

// File: rtl/hash_word_sequencer.sv
// Buffers a 256-bit hash and presents one 32-bit word at a time, stepped by debounced buttons
// or auto-scroll. Define WORD_INDEX_OVERLAY_EN to show the word number in Word[31:28].
module hash_word_sequencer #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
  parameter logic [27:0] SCROLL_CYCLES   = 28'd200000000
) (
  input  logic                        clk_in,
  input  logic                        reset,
  hash_word_sequencer_if.slave        hash_if,
  input  logic                        hold_in,
  input  logic                        auto_scroll_in,
  input  logic                        BTNU_in,
  input  logic                        BTND_in,
  output logic [31:0]                 Word,
  output logic [2:0]                  word_index,
  output logic                        loaded
);

  typedef enum logic [0:0] {StEmpty, StShow} state_e;

  state_e           state_q, state_d;
  logic [7:0][31:0] buf_q, buf_d;
  logic [2:0]       idx_q, idx_d;
  logic [27:0]      scroll_q, scroll_d;

  // Bit 0 is the up button, bit 1 the down button.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       deb_q, deb_d;
  logic [1:0]       deb_prev_q;
  logic [1:0][19:0] cnt_q, cnt_d;
  logic             step_up, step_dn;
  logic             capture;
  logic [31:0]      sel_word;

  assign btn_raw = {BTND_in, BTNU_in};

  // ---------------------------------------------------------------------------------------------
  // Button synchronizers and debouncers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == DEBOUNCE_CYCLES - 20'd1) begin
          deb_d[b] = sync2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 20'd1;
        end
      end
    end
  end

  // Rising edge of the debounced level only, so a held button steps once.
  assign step_up = deb_q[0] & ~deb_prev_q[0];
  assign step_dn = deb_q[1] & ~deb_prev_q[1];

  // ---------------------------------------------------------------------------------------------
  // Capture handshake
  // ---------------------------------------------------------------------------------------------
  assign hash_if.hash_ready = ~reset & ~hold_in;
  assign capture            = hash_if.hash_valid & hash_if.hash_ready;

  // ---------------------------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q  <= StEmpty;
      buf_q    <= '0;
      idx_q    <= '0;
      scroll_q <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      idx_q    <= idx_d;
      scroll_q <= scroll_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    scroll_d = scroll_q;

    if (capture) begin
      buf_d    = hash_if.hash_in;
      idx_d    = 3'd0;
      scroll_d = '0;
      state_d  = StShow;
    end else begin
      unique case (state_q)
        StEmpty: begin
          scroll_d = '0;
        end
        StShow: begin
          if (step_up | step_dn) begin
            scroll_d = '0;
            // Simultaneous up and down cancel out.
            if (step_up ^ step_dn) begin
              idx_d = step_up ? idx_q + 3'd1 : idx_q - 3'd1;
            end
          end else if (!auto_scroll_in) begin
            scroll_d = '0;
          end else if (scroll_q == SCROLL_CYCLES - 28'd1) begin
            scroll_d = '0;
            idx_d    = idx_q + 3'd1;
          end else begin
            scroll_d = scroll_q + 28'd1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign sel_word   = buf_q[idx_q];
  assign loaded     = (state_q == StShow);
  assign word_index = loaded ? idx_q : 3'd0;

  always_comb begin
    Word = '0;
    if (loaded) begin
`ifdef WORD_INDEX_OVERLAY_EN
      Word = {1'b0, idx_q, sel_word[27:0]};
`else
      Word = sel_word;
`endif
    end
  end

endmodule
